// File: rtl/led_blink_seq.sv
// Programmable LED blink sequencer: accepts {on, off, count} commands over a
// valid/ready handshake and drives the LED through the requested on/off cycles.
module led_blink_seq #(
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned TW       = 16,
   parameter int unsigned CW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [TW-1:0] cmd_on,
   input  logic [TW-1:0] cmd_off,
   input  logic [CW-1:0] cmd_count,
   input  logic          abort,
   output logic          led,
   output logic          busy,
   output logic          done
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          led_q, led_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [TW-1:0] phase_q, phase_d;
   logic [TW-1:0] on_q, on_d;
   logic [TW-1:0] off_q, off_d;
   logic [CW-1:0] count_q, count_d;

   logic          accept;
   logic          tick;
   logic          last_tick;
   logic [TW-1:0] cmd_on_eff;
   logic [TW-1:0] cmd_off_eff;

   assign cmd_ready   = (state_q == IDLE) & ~abort;
   assign accept      = cmd_valid & cmd_ready;
   assign tick        = (presc_q == PRESC_LAST);
   assign last_tick   = (phase_q <= TW'(1));

   // Zero-length phases are stretched to one tick so no phase is ever skipped.
   assign cmd_on_eff  = (cmd_on  == '0) ? TW'(1) : cmd_on;
   assign cmd_off_eff = (cmd_off == '0) ? TW'(1) : cmd_off;

   assign led  = led_q;
   assign busy = busy_q;
   assign done = done_q;

   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      presc_d = presc_q;
      phase_d = phase_q;
      on_d    = on_q;
      off_d   = off_q;
      count_d = count_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               on_d    = cmd_on_eff;
               off_d   = cmd_off_eff;
               count_d = cmd_count;
               phase_d = cmd_on_eff;
               presc_d = '0;
               state_d = ON;
               led_d   = 1'b1;
               busy_d  = 1'b1;
            end
         end

         ON, OFF: begin
            if (abort) begin
               state_d = IDLE;
               led_d   = 1'b0;
               busy_d  = 1'b0;
               presc_d = '0;
            end else begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick && !last_tick) begin
                  phase_d = phase_q - TW'(1);
               end else if (tick && state_q == ON) begin
                  state_d = OFF;
                  led_d   = 1'b0;
                  phase_d = off_q;
               end else if (tick && count_q == CW'(1)) begin
                  state_d = IDLE;
                  led_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (tick) begin
                  // A zero repeat count stays at zero and so never terminates.
                  if (count_q != '0) begin
                     count_d = count_q - CW'(1);
                  end
                  state_d = ON;
                  led_d   = 1'b1;
                  phase_d = on_q;
               end
            end
         end

         default: begin
            state_d = IDLE;
            led_d   = 1'b0;
            busy_d  = 1'b0;
            presc_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         presc_q <= '0;
         phase_q <= '0;
         on_q    <= '0;
         off_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         presc_q <= presc_d;
         phase_q <= phase_d;
         on_q    <= on_d;
         off_q   <= off_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_led_blink_seq.sv
// Self-checking bench for led_blink_seq: directed scenarios plus random traffic,
// compared cycle by cycle against an arithmetic model of the blink schedule.
module tb_led_blink_seq;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] cmd_on = '0;
   logic [15:0] cmd_off = '0;
   logic [7:0]  cmd_count = '0;
   logic        cmd_ready;
   logic        led;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;
   int edge_num = 0;

   bit m_busy = 1'b0;
   int m_k = 0;
   int m_n = 1;
   int m_m = 1;
   int m_c = 0;

   always #5 clk = ~clk;

   led_blink_seq #(
      .TICK_DIV (TD),
      .TW       (16),
      .CW       (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_on    (cmd_on),
      .cmd_off   (cmd_off),
      .cmd_count (cmd_count),
      .abort     (abort),
      .led       (led),
      .busy      (busy),
      .done      (done)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, edge_num, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic ab, input logic [15:0] on,
                                input logic [15:0] off, input logic [7:0] cnt);
      cmd_valid = v;
      abort     = ab;
      cmd_on    = on;
      cmd_off   = off;
      cmd_count = cnt;
   endtask

   // One clock: check ready, advance the model across the edge, check outputs.
   // The model treats a sequence as a schedule starting at edge m_k: within
   // each period of (N+M)*TD cycles the LED is lit for the first N*TD cycles,
   // and a finite sequence ends exactly C periods after the accept edge.
   task automatic step();
      bit fin;
      int t;
      int period;
      fin = 1'b0;
      #1;
      checkOutput("cmd_ready", cmd_ready, (!m_busy && !abort));
      if (!m_busy) begin
         if (cmd_valid && !abort) begin
            m_busy = 1'b1;
            m_k = edge_num + 1;
            m_n = (cmd_on == 0) ? 1 : int'(cmd_on);
            m_m = (cmd_off == 0) ? 1 : int'(cmd_off);
            m_c = int'(cmd_count);
         end
      end else if (abort) begin
         m_busy = 1'b0;
      end else if (m_c != 0 && (edge_num + 1 - m_k) == m_c * (m_n + m_m) * TD) begin
         m_busy = 1'b0;
         fin = 1'b1;
      end
      @(posedge clk);
      #1;
      edge_num++;
      if (m_busy) begin
         t = edge_num - m_k;
         period = (m_n + m_m) * TD;
         checkOutput("led", led, ((t % period) < m_n * TD));
         checkOutput("busy", busy, 1);
         checkOutput("done", done, 0);
      end else begin
         checkOutput("led", led, 0);
         checkOutput("busy", busy, 0);
         checkOutput("done", done, fin);
      end
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (m_busy && n < budget) begin
         step();
         n++;
      end
      checkOutput("idle_timeout", busy, 0);
   endtask

   initial begin
      // Reset held for three cycles; outputs must already be at reset values.
      #1;
      checkOutput("rst_led", led, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_ready", cmd_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (20) step();

      // Basic: on=2 off=3 count=2.
      applyStimulus(1, 0, 16'd2, 16'd3, 8'd2);
      step();
      applyStimulus(0, 0, 16'd9, 16'd9, 8'd9);
      waitIdle(60);
      repeat (3) step();

      // Zero fields act as one tick each.
      applyStimulus(1, 0, 16'd0, 16'd0, 8'd1);
      step();
      applyStimulus(0, 0, 16'd0, 16'd0, 8'd0);
      waitIdle(20);
      repeat (2) step();

      // Infinite mode, aborted mid-ON after ten full periods.
      applyStimulus(1, 0, 16'd1, 16'd1, 8'd0);
      step();
      applyStimulus(0, 0, 16'd0, 16'd0, 8'd0);
      for (int i = 0; i < 120; i++) begin
         if ((edge_num - m_k) >= 10 * 2 * TD && ((edge_num - m_k) % (2 * TD)) == 1) break;
         step();
      end
      applyStimulus(0, 1, 16'd0, 16'd0, 8'd0);
      step();
      applyStimulus(0, 0, 16'd0, 16'd0, 8'd0);
      repeat (3) step();

      // Abort in IDLE, alone and with a pending command: nothing happens.
      applyStimulus(0, 1, 16'd0, 16'd0, 8'd0);
      step();
      applyStimulus(1, 1, 16'd2, 16'd2, 8'd1);
      repeat (3) step();
      applyStimulus(0, 0, 16'd0, 16'd0, 8'd0);
      step();

      // Valid held while busy: second command accepted right after done.
      applyStimulus(1, 0, 16'd1, 16'd1, 8'd1);
      step();
      applyStimulus(1, 0, 16'd2, 16'd1, 8'd1);
      waitIdle(20);
      step();
      applyStimulus(0, 0, 16'd5, 16'd5, 8'd5);
      waitIdle(30);
      repeat (2) step();

      // Random traffic with occasional aborts and field jitter while busy.
      for (int i = 0; i < 800; i++) begin
         applyStimulus(($urandom_range(3) == 0), ($urandom_range(24) == 0),
                       16'($urandom_range(3)), 16'($urandom_range(3)), 8'($urandom_range(3)));
         step();
      end
      applyStimulus(0, 1, 16'd0, 16'd0, 8'd0);
      step();
      applyStimulus(0, 0, 16'd0, 16'd0, 8'd0);
      repeat (2) step();

      // Asynchronous reset mid-ON, then a fresh command runs normally.
      applyStimulus(1, 0, 16'd3, 16'd2, 8'd2);
      step();
      applyStimulus(0, 0, 16'd0, 16'd0, 8'd0);
      repeat (5) step();
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midrst_led", led, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_ready", cmd_ready, 1);
      m_busy = 1'b0;
      @(posedge clk);
      edge_num++;
      @(posedge clk);
      edge_num++;
      #1;
      reset = 1'b1;
      step();
      applyStimulus(1, 0, 16'd1, 16'd2, 8'd1);
      step();
      applyStimulus(0, 0, 16'd0, 16'd0, 8'd0);
      waitIdle(30);
      repeat (2) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
